key_tracker: RTL and testbench

Sequential owner of the `key_find` progress code consumed by the object renderer. During `STAGE1` it watches the player position and a search button. It advances `key_find` through the three key pickups and then the door. It emits one-cycle event pulses for the sound and scene-control logic. Outside `STAGE1` it holds progress at `NONE`, so every stage entry starts clean.

---
 rtl/game_pkg.sv | 31 +++
 rtl/box_hit.sv | 12 +
 rtl/key_tracker.sv | 72 +++++++
 tb/tb_key_tracker.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared scene codes, key progress codes, target boxes and tracker FSM states
package game_pkg;
  typedef enum logic [3:0] {
    TITLE  = 4'd0,
    MENU   = 4'd1,
    STAGE1 = 4'd2,
    STAGE2 = 4'd3,
    WIN    = 4'd4,
    FAIL   = 4'd5
  } scene_t;
  typedef enum logic [1:0] {
    NONE       = 2'd0,
    FIND_KEY   = 2'd1,
    FIND_LIGHT = 2'd2,
    FIND_DOOR  = 2'd3
  } key_find_t;
  typedef enum logic [1:0] {IDLE, SEEK, COOL, DONE} tracker_t;
  typedef struct packed {
    logic [8:0] x0;
    logic [8:0] x1;
    logic [8:0] y0;
    logic [8:0] y1;
  } box_t;
  localparam box_t BOX_KEY1  = '{x0: 9'd65,  x1: 9'd85,  y0: 9'd35,  y1: 9'd55};
  localparam box_t BOX_KEY2  = '{x0: 9'd235, x1: 9'd255, y0: 9'd35,  y1: 9'd55};
  localparam box_t BOX_KEY3  = '{x0: 9'd235, x1: 9'd255, y0: 9'd205, y1: 9'd225};
  localparam box_t BOX_DOOR  = '{x0: 9'd145, x1: 9'd175, y0: 9'd100, y1: 9'd140};
  function automatic box_t box_of(input logic [1:0] kf);
    return kf == NONE ? BOX_KEY1 : kf == FIND_KEY ? BOX_KEY2 : kf == FIND_LIGHT ? BOX_KEY3 : BOX_DOOR;
  endfunction
endpackage

// File: rtl/box_hit.sv
// box_hit: point-in-box test, inclusive low / exclusive high bounds; ports x,y point, x0..y1 bounds, hit result
module box_hit (
  input  logic [8:0] x,
  input  logic [8:0] y,
  input  logic [8:0] x0,
  input  logic [8:0] x1,
  input  logic [8:0] y0,
  input  logic [8:0] y1,
  output logic       hit
);
  assign hit = x >= x0 && x < x1 && y >= y0 && y < y1;
endmodule

// File: rtl/key_tracker.sv
// key_tracker: stage-1 key/door progress FSM; in clk,rst,state,player_x/y,search; out key_find,pickup,stage_clear,hold_cnt
module key_tracker
  import game_pkg::*;
#(
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int COOLDOWN_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  state,
  input  logic [8:0]  player_x,
  input  logic [8:0]  player_y,
  input  logic        search,
  output logic [1:0]  key_find,
  output logic        pickup,
  output logic        stage_clear,
  output logic [24:0] hold_cnt
);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  tracker_t fsm;
  logic [CW-1:0] cool_cnt;
  box_t box;
  logic hit;
  always_comb box = box_of(key_find);
  box_hit u_box_hit (
    .x  (player_x),
    .y  (player_y),
    .x0 (box.x0),
    .x1 (box.x1),
    .y0 (box.y0),
    .y1 (box.y1),
    .hit(hit)
  );
  always_ff @(posedge clk) begin
    if (rst || state != STAGE1) begin
      fsm         <= IDLE;
      key_find    <= NONE;
      pickup      <= 1'b0;
      stage_clear <= 1'b0;
      hold_cnt    <= '0;
      cool_cnt    <= '0;
    end else begin
      pickup      <= 1'b0;
      stage_clear <= 1'b0;
      case (fsm)
        IDLE: fsm <= SEEK;
        SEEK: begin
          if (!(hit && search)) hold_cnt <= '0;
          else if (hold_cnt == 25'(HOLD_CYCLES - 1)) begin
            hold_cnt <= '0;
            if (key_find != FIND_DOOR) begin
              key_find <= key_find + 2'd1;
              pickup   <= 1'b1;
              cool_cnt <= '0;
              fsm      <= COOL;
            end else begin
              stage_clear <= 1'b1;
              fsm         <= DONE;
            end
          end else hold_cnt <= hold_cnt + 25'd1;
        end
        COOL: begin
          hold_cnt <= '0;
          cool_cnt <= cool_cnt == CW'(COOLDOWN_CYCLES - 1) ? '0 : cool_cnt + 1'b1;
          fsm      <= cool_cnt == CW'(COOLDOWN_CYCLES - 1) ? SEEK : COOL;
        end
        DONE: fsm <= DONE;
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_tracker.sv
// tb_key_tracker: directed checks of key_tracker with short hold/cooldown
module tb_key_tracker;
  logic        clk, rst, search;
  logic [3:0]  state;
  logic [8:0]  px, py;
  logic [1:0]  key_find;
  logic        pickup, stage_clear;
  logic [24:0] hold_cnt;
  int checks = 0;
  int failures = 0;
  key_tracker #(.HOLD_CYCLES(4), .COOLDOWN_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .state(state), .player_x(px), .player_y(py),
    .search(search), .key_find(key_find), .pickup(pickup),
    .stage_clear(stage_clear), .hold_cnt(hold_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int n, output int pk, output int sc, output int last_pk, output int last_sc);
    pk = 0; sc = 0; last_pk = 0; last_sc = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (pickup) begin pk++; last_pk = i; end
      if (stage_clear) begin sc++; last_sc = i; end
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; search = 1'b0; state = 4'd2;
    tick();
    rst = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b1; state = 4'd2; px = 9'd70; py = 9'd40; search = 1'b1;
    tick(); tick();
    checks++; if (key_find !== 2'd0) begin failures++; $display("FAIL reset_kf got=%0d exp=0", key_find); end
    checks++; if (hold_cnt !== 25'd0) begin failures++; $display("FAIL reset_hold got=%0d exp=0", hold_cnt); end
    checks++; if ({pickup, stage_clear} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {pickup, stage_clear}); end
    rst = 1'b0;
    tick(); tick(); tick();
    checks++; if (hold_cnt !== 25'd2) begin failures++; $display("FAIL reset_midhold got=%0d exp=2", hold_cnt); end
    rst = 1'b1;
    tick(); tick();
    checks++; if (hold_cnt !== 25'd0 || key_find !== 2'd0 || pickup !== 1'b0) begin
      failures++; $display("FAIL reset_again got hold=%0d kf=%0d pk=%b exp 0/0/0", hold_cnt, key_find, pickup); end
    rst = 1'b0; search = 1'b0;
  endtask
  task automatic test_key1();
    int pk, sc, lp, ls;
    do_reset();
    px = 9'd70; py = 9'd40; search = 1'b1;
    run(3, pk, sc, lp, ls);
    checks++; if (pk !== 0 || hold_cnt !== 25'd3) begin failures++; $display("FAIL key1_early got pk=%0d hold=%0d exp 0/3", pk, hold_cnt); end
    tick();
    checks++; if (pickup !== 1'b1 || key_find !== 2'd1) begin failures++; $display("FAIL key1_pickup got pk=%b kf=%0d exp 1/1", pickup, key_find); end
    tick();
    checks++; if (pickup !== 1'b0) begin failures++; $display("FAIL key1_pulse_width got=%b exp=0", pickup); end
  endtask
  task automatic test_broken();
    int pk, sc, lp, ls;
    do_reset();
    px = 9'd70; py = 9'd40; search = 1'b1;
    run(3, pk, sc, lp, ls);
    search = 1'b0;
    tick();
    checks++; if (hold_cnt !== 25'd0 || pk !== 0) begin failures++; $display("FAIL broken_clear got hold=%0d pk=%0d exp 0/0", hold_cnt, pk); end
    search = 1'b1;
    run(4, pk, sc, lp, ls);
    checks++; if (pk !== 1 || lp !== 4) begin failures++; $display("FAIL broken_second got pk=%0d at=%0d exp 1 at 4", pk, lp); end
    search = 1'b0;
    run(5, pk, sc, lp, ls);
    checks++; if (pk !== 0 || key_find !== 2'd1) begin failures++; $display("FAIL broken_after got pk=%0d kf=%0d exp 0/1", pk, key_find); end
  endtask
  task automatic test_cooldown();
    int pk, sc, lp, ls;
    do_reset();
    px = 9'd70; py = 9'd40; search = 1'b1;
    run(4, pk, sc, lp, ls);
    px = 9'd240;
    run(7, pk, sc, lp, ls);
    checks++; if (pk !== 1 || lp !== 7) begin failures++; $display("FAIL cooldown_key2 got pk=%0d at=%0d exp 1 at 7", pk, lp); end
    checks++; if (key_find !== 2'd2) begin failures++; $display("FAIL cooldown_kf got=%0d exp=2", key_find); end
  endtask
  task automatic test_boundary();
    int pk, sc, lp, ls;
    do_reset();
    px = 9'd85; py = 9'd40; search = 1'b1;
    run(6, pk, sc, lp, ls);
    checks++; if (pk !== 0 || hold_cnt !== 25'd0) begin failures++; $display("FAIL bound_x1_excl got pk=%0d hold=%0d exp 0/0", pk, hold_cnt); end
    px = 9'd84; py = 9'd54;
    run(4, pk, sc, lp, ls);
    checks++; if (pk !== 1 || lp !== 4) begin failures++; $display("FAIL bound_inside got pk=%0d at=%0d exp 1 at 4", pk, lp); end
  endtask
  task automatic test_full();
    int pk, sc, lp, ls, tpk, tsc;
    do_reset();
    search = 1'b1; tpk = 0; tsc = 0;
    px = 9'd70;  py = 9'd40;  run(4, pk, sc, lp, ls); tpk += pk; tsc += sc;
    px = 9'd240; py = 9'd40;  run(7, pk, sc, lp, ls); tpk += pk; tsc += sc;
    px = 9'd240; py = 9'd210; run(7, pk, sc, lp, ls); tpk += pk; tsc += sc;
    checks++; if (key_find !== 2'd3) begin failures++; $display("FAIL full_kf3 got=%0d exp=3", key_find); end
    px = 9'd150; py = 9'd120; run(7, pk, sc, lp, ls); tpk += pk; tsc += sc;
    checks++; if (tpk !== 3 || tsc !== 1 || ls !== 7) begin failures++; $display("FAIL full_pulses got pk=%0d sc=%0d at=%0d exp 3/1 at 7", tpk, tsc, ls); end
    run(20, pk, sc, lp, ls);
    checks++; if (pk !== 0 || sc !== 0 || key_find !== 2'd3 || hold_cnt !== 25'd0) begin
      failures++; $display("FAIL full_done got pk=%0d sc=%0d kf=%0d hold=%0d exp 0/0/3/0", pk, sc, key_find, hold_cnt); end
  endtask
  task automatic test_exit();
    int pk, sc, lp, ls;
    do_reset();
    search = 1'b1;
    px = 9'd70;  py = 9'd40;  run(4, pk, sc, lp, ls);
    px = 9'd240; py = 9'd40;  run(7, pk, sc, lp, ls);
    px = 9'd240; py = 9'd210; run(5, pk, sc, lp, ls);
    checks++; if (key_find !== 2'd2 || hold_cnt !== 25'd2) begin failures++; $display("FAIL exit_setup got kf=%0d hold=%0d exp 2/2", key_find, hold_cnt); end
    state = 4'd3;
    tick();
    checks++; if (key_find !== 2'd0 || pickup !== 1'b0 || hold_cnt !== 25'd0) begin
      failures++; $display("FAIL exit_clear got kf=%0d pk=%b hold=%0d exp 0/0/0", key_find, pickup, hold_cnt); end
    run(3, pk, sc, lp, ls);
    checks++; if (pk !== 0 || key_find !== 2'd0) begin failures++; $display("FAIL exit_idle got pk=%0d kf=%0d exp 0/0", pk, key_find); end
    state = 4'd2; px = 9'd70; py = 9'd40;
    tick();
    run(4, pk, sc, lp, ls);
    checks++; if (pk !== 1 || lp !== 4 || key_find !== 2'd1) begin failures++; $display("FAIL exit_restart got pk=%0d at=%0d kf=%0d exp 1 at 4 kf 1", pk, lp, key_find); end
    run(3, pk, sc, lp, ls);
    px = 9'd240; py = 9'd40;
    run(3, pk, sc, lp, ls);
    checks++; if (hold_cnt !== 25'd3) begin failures++; $display("FAIL exit_prehold got=%0d exp=3", hold_cnt); end
    state = 4'd3;
    tick();
    checks++; if (pickup !== 1'b0 || key_find !== 2'd0) begin failures++; $display("FAIL exit_coincide got pk=%b kf=%0d exp 0/0", pickup, key_find); end
  endtask
  initial begin
    rst = 1'b1; state = 4'd0; px = '0; py = '0; search = 1'b0;
    test_reset();
    test_key1();
    test_broken();
    test_cooldown();
    test_boundary();
    test_full();
    test_exit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
